// File: rtl/plic_target_gateway_if.sv
// plic_target_gateway_if
//   Claim/complete transaction bus between the CSR/bus requester and the
//   per-target gateway.
//
//   Parameters:
//     M               index width ($clog2 of the number of sources)
//
//   Signals (direction given from the slave, i.e. gateway, side):
//     claim_req       in   single-cycle claim request pulse
//     claim_ack       out  claim response strobe (one cycle)
//     claim_valid     out  claim returned a source
//     claim_index     out  claimed source index (0 when claim_valid=0)
//     complete_req    in   single-cycle complete request pulse
//     complete_index  in   index being completed
//     complete_ack    out  complete response strobe (one cycle)
interface plic_target_gateway_if #(
    parameter int M = 2
) ();

    logic         claim_req;
    logic         claim_ack;
    logic         claim_valid;
    logic [M-1:0] claim_index;
    logic         complete_req;
    logic [M-1:0] complete_index;
    logic         complete_ack;

    modport master (
        output claim_req,
        output complete_req,
        output complete_index,
        input  claim_ack,
        input  claim_valid,
        input  claim_index,
        input  complete_ack
    );

    modport slave (
        input  claim_req,
        input  complete_req,
        input  complete_index,
        output claim_ack,
        output claim_valid,
        output claim_index,
        output complete_ack
    );

endinterface

// File: rtl/plic_target_gateway.sv
// plic_target_gateway
//   Per-target interrupt gateway and claim/complete engine. Each source has
//   a small state machine (IDLE / PENDING / IN_SERVICE). Enabled pending
//   sources are presented to an external priority search tree, whose winner
//   is used to raise the hart external interrupt and to answer claims.
//
//   Parameters:
//     N  number of sources (power of 2, >= 2)
//     W  priority width (>= 1)
//     M  (local) index width, $clog2(N)
//
//   Ports:
//     i_clk            clock
//     i_rst            asynchronous active-high reset
//     i_irq[N]         level-sensitive source requests
//     i_enable[N]      per-source enable for this target
//     i_priorities     per-source priority, 0 = never interrupts
//     i_threshold      target threshold (strict greater-than compare)
//     o_pending[N]     enabled pending vector to the priority tree
//     i_best_index     tree winning index (combinational from o_pending)
//     i_best_valid     tree winner valid
//     o_eip            external interrupt pending to the hart
//     bus              claim/complete transaction bus (slave side)
module plic_target_gateway #(
    parameter  int N = 4,
    parameter  int W = 2,
    localparam int M = $clog2(N)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N-1:0]          i_irq,
    input  logic [N-1:0]          i_enable,
    input  logic [W-1:0]          i_priorities [N-1:0],
    input  logic [W-1:0]          i_threshold,
    output logic [N-1:0]          o_pending,
    input  logic [M-1:0]          i_best_index,
    input  logic                  i_best_valid,
    output logic                  o_eip,
    plic_target_gateway_if.slave  bus
);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("plic_target_gateway: N must be a power of 2 and >= 2");
    end

    if (W < 1) begin : g_bad_w
        $error("plic_target_gateway: W must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PENDING    = 2'd1,
        IN_SERVICE = 2'd2
    } src_state_t;

    src_state_t   state [N];
    logic [N-1:0] enable_q;
    logic         eligible;
    logic         claim_hit;

    // The tree winner is only worth interrupting for when it beats the
    // threshold; priority 0 can never beat any threshold.
    always_comb begin
        eligible  = i_best_valid && (i_priorities[i_best_index] > i_threshold);
        claim_hit = bus.claim_req && eligible;
    end

    // Built purely from flops so the tree sees a glitch-free, registered
    // vector with no combinational path from the request inputs.
    always_comb begin
        o_pending = '0;
        for (int unsigned k = 0; k < N; k++) begin
            o_pending[k] = (state[k] == PENDING) && enable_q[k];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < N; k++) begin
                state[k] <= IDLE;
            end
            enable_q         <= '0;
            o_eip            <= 1'b0;
            bus.claim_ack    <= 1'b0;
            bus.claim_valid  <= 1'b0;
            bus.claim_index  <= '0;
            bus.complete_ack <= 1'b0;
        end else begin
            enable_q         <= i_enable;
            o_eip            <= eligible;
            bus.claim_ack    <= bus.claim_req;
            bus.claim_valid  <= claim_hit;
            bus.claim_index  <= claim_hit ? i_best_index : '0;
            bus.complete_ack <= bus.complete_req;

            // A claim only ever hits a PENDING source and a complete only
            // acts on an IN_SERVICE one, so both may be handled on the same
            // edge without conflicting on any single source.
            for (int unsigned k = 0; k < N; k++) begin
                case (state[k])
                    IDLE: begin
                        if (i_irq[k]) begin
                            state[k] <= PENDING;
                        end
                    end
                    PENDING: begin
                        if (claim_hit && (i_best_index == M'(k))) begin
                            state[k] <= IN_SERVICE;
                        end
                    end
                    IN_SERVICE: begin
                        if (bus.complete_req && (bus.complete_index == M'(k))) begin
                            state[k] <= IDLE;
                        end
                    end
                    default: begin
                        state[k] <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_plic_target_gateway.sv
// tb_plic_target_gateway
//   Directed bench for plic_target_gateway (N=4, W=2). Includes a behavioural
//   priority tree (highest priority wins, lowest index on ties). Expected
//   claim responses are queued when a claim is issued and compared when the
//   ack arrives.
module tb_plic_target_gateway;

    localparam int N = 4;
    localparam int W = 2;
    localparam int M = 2;

    typedef struct {
        string        tag;
        logic         valid;
        logic [M-1:0] index;
    } claim_exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq;
    logic [N-1:0] enable;
    logic [W-1:0] prio [N-1:0];
    logic [W-1:0] threshold;
    logic [N-1:0] pending;
    logic [M-1:0] best_index;
    logic         best_valid;
    logic [W-1:0] best_prio;
    logic         eip;

    int vectors     = 0;
    int miscompares = 0;

    claim_exp_t sb [$];

    plic_target_gateway_if #(.M(M)) bus ();

    plic_target_gateway #(.N(N), .W(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_irq        (irq),
        .i_enable     (enable),
        .i_priorities (prio),
        .i_threshold  (threshold),
        .o_pending    (pending),
        .i_best_index (best_index),
        .i_best_valid (best_valid),
        .o_eip        (eip),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Priority tree model: highest priority among pending sources.
    always_comb begin
        best_valid = 1'b0;
        best_index = '0;
        best_prio  = '0;
        for (int k = 0; k < N; k++) begin
            if (pending[k] && (!best_valid || prio[k] > best_prio)) begin
                best_valid = 1'b1;
                best_index = M'(k);
                best_prio  = prio[k];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_claim(input string tag, input logic v, input logic [M-1:0] idx);
        claim_exp_t e;
        sb.push_back('{tag, v, idx});
        bus.claim_req = 1'b1;
        step();
        bus.claim_req = 1'b0;
        check({tag, "_ack"}, 32'(bus.claim_ack), 32'd1);
        e = sb.pop_front();
        check({e.tag, "_valid"}, 32'(bus.claim_valid), 32'(e.valid));
        check({e.tag, "_index"}, 32'(bus.claim_index), 32'(e.index));
    endtask

    task automatic do_complete(input string tag, input logic [M-1:0] idx);
        bus.complete_req   = 1'b1;
        bus.complete_index = idx;
        step();
        bus.complete_req   = 1'b0;
        bus.complete_index = '0;
        check({tag, "_ack"}, 32'(bus.complete_ack), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        claim_exp_t e;
        irq                = 4'b1111;
        enable             = 4'b1111;
        prio[0]            = 2'd3;
        prio[1]            = 2'd1;
        prio[2]            = 2'd2;
        prio[3]            = 2'd1;
        threshold          = '0;
        bus.claim_req      = 1'b0;
        bus.complete_req   = 1'b0;
        bus.complete_index = '0;

        // Reset with all requests high.
        step();
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_eip", 32'(eip), 32'd0);
        check("rst_claim_ack", 32'(bus.claim_ack), 32'd0);
        check("rst_claim_valid", 32'(bus.claim_valid), 32'd0);
        check("rst_claim_index", 32'(bus.claim_index), 32'd0);
        check("rst_complete_ack", 32'(bus.complete_ack), 32'd0);
        rst = 1'b0;
        step();
        check("rel_pending", 32'(pending), 32'hF);
        check("rel_eip_early", 32'(eip), 32'd0);
        step();
        check("rel_eip", 32'(eip), 32'd1);

        // Fresh start with only sources 2 and 1 requesting.
        irq = 4'b0110;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        check("t2_pending", 32'(pending), 32'h6);
        check("t2_eip", 32'(eip), 32'd1);
        do_claim("claim1", 1'b1, 2'd2);
        check("claim1_pending", 32'(pending), 32'h2);
        do_claim("claim2", 1'b1, 2'd1);
        check("claim2_pending", 32'(pending), 32'h0);
        do_claim("claim3", 1'b0, 2'd0);
        check("claim3_eip", 32'(eip), 32'd0);
        irq = 4'b0000;
        do_complete("cmp2", 2'd2);
        do_complete("cmp1", 2'd1);

        // Threshold boundary: priority equal to threshold never interrupts.
        prio[1]   = 2'd2;
        threshold = 2'd2;
        irq       = 4'b0010;
        step();
        step();
        step();
        check("thr_pending", 32'(pending), 32'h2);
        check("thr_eip", 32'(eip), 32'd0);
        do_claim("thr_claim", 1'b0, 2'd0);
        step();
        check("thr_still_pending", 32'(pending), 32'h2);
        threshold = 2'd1;
        step();
        step();
        check("thr_lowered_eip", 32'(eip), 32'd1);
        do_claim("thr_claim2", 1'b1, 2'd1);
        irq       = 4'b0000;
        threshold = 2'd0;
        do_complete("thr_cmp1", 2'd1);

        // In-service source ignores its held request until completed.
        irq = 4'b1000;
        step();
        step();
        do_claim("svc_claim", 1'b1, 2'd3);
        step();
        step();
        check("svc_no_repend", 32'(pending), 32'h0);
        do_complete("svc_cmp3", 2'd3);
        check("svc_after_cmp", 32'(pending), 32'h0);
        step();
        check("svc_repend", 32'(pending), 32'h8);
        do_complete("idle_cmp0", 2'd0);
        step();
        check("idle_cmp_nochange", 32'(pending), 32'h8);
        do_claim("svc_claim2", 1'b1, 2'd3);
        irq = 4'b0000;
        do_complete("svc_cmp3b", 2'd3);

        // Same-cycle claim of source 1 and complete of in-service source 0.
        irq = 4'b0001;
        step();
        step();
        do_claim("sim_pre_claim", 1'b1, 2'd0);
        irq = 4'b0010;
        step();
        step();
        sb.push_back('{"sim_claim", 1'b1, 2'd1});
        bus.claim_req      = 1'b1;
        bus.complete_req   = 1'b1;
        bus.complete_index = 2'd0;
        step();
        bus.claim_req      = 1'b0;
        bus.complete_req   = 1'b0;
        check("sim_claim_ack", 32'(bus.claim_ack), 32'd1);
        check("sim_complete_ack", 32'(bus.complete_ack), 32'd1);
        e = sb.pop_front();
        check({e.tag, "_valid"}, 32'(bus.claim_valid), 32'(e.valid));
        check({e.tag, "_index"}, 32'(bus.claim_index), 32'(e.index));
        irq = 4'b0011;
        step();
        check("sim_states", 32'(pending), 32'h1);

        // Asynchronous reset while a claim ack is being presented.
        step();
        sb.push_back('{"rst_claim", 1'b1, 2'd0});
        bus.claim_req = 1'b1;
        step();
        bus.claim_req = 1'b0;
        check("rstmid_ack_before", 32'(bus.claim_ack), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("rstmid_ack", 32'(bus.claim_ack), 32'd0);
        check("rstmid_valid", 32'(bus.claim_valid), 32'd0);
        check("rstmid_index", 32'(bus.claim_index), 32'd0);
        check("rstmid_pending", 32'(pending), 32'd0);
        check("rstmid_eip", 32'(eip), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_pending", 32'(pending), 32'h3);
        check("post_rst_ack0", 32'(bus.claim_ack), 32'd0);
        step();
        check("post_rst_ack1", 32'(bus.claim_ack), 32'd0);
        check("post_rst_cack", 32'(bus.complete_ack), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/plic_target_gateway.md
# plic_target_gateway

Per-target interrupt gateway and claim/complete engine for the platform-level interrupt controller. It latches level-sensitive source requests into per-source pending state and drives the enabled pending vector into the priority search tree. It consumes the tree's winning index to raise the hart's external-interrupt line and to serve claim/complete transactions from the CSR/bus side. It is the consumer end of the priority-selection path: the tree selects, this block owns the state and acts on the selection.

## Interface
Parameters:
- N, 4, number of interrupt sources; power of 2, ≥ 2 (elaborate-time $error otherwise)
- W, 2, priority width; ≥ 1
- M (local), $clog2(N), index width

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  reset, asynchronous, active-high
- i_irq  in  N  level-sensitive source request lines, synchronous to i_clk
- i_enable  in  N  per-source enable for this target
- i_priorities  in  W×N (unpacked [N-1:0])  per-source priority; 0 = never interrupts
- i_threshold  in  W  target threshold
- o_pending  out  N  registered pending & enable vector, drives tree i_pending
- i_best_index  in  M  tree winning index (combinational from o_pending)
- i_best_valid  in  1  tree valid
- o_eip  out  1  external interrupt pending to hart
- i_claim_req  in  1  claim request, single-cycle pulse
- o_claim_ack  out  1  claim response strobe
- o_claim_valid  out  1  claim returned a source
- o_claim_index  out  M  claimed source index
- i_complete_req  in  1  complete request, single-cycle pulse
- i_complete_index  in  M  index being completed
- o_complete_ack  out  1  complete response strobe

## Operation
- Per-source 2-bit state: IDLE, PENDING, IN_SERVICE.
- IDLE → PENDING when i_irq[k]=1 (sampled at clock edge); i_enable does not gate capture.
- PENDING → IN_SERVICE on a successful claim of k; pending bit clears in the same edge.
- IN_SERVICE → IDLE on complete with i_complete_index==k; i_irq[k] ignored while IN_SERVICE. If i_irq[k] is still high after completion, source re-enters PENDING one cycle later.
- Complete for a source not IN_SERVICE: acknowledged, no state change.
- o_pending[k] = (state[k]==PENDING) & i_enable[k], registered from state and registered enable.
- Eligible = i_best_valid && i_priorities[i_best_index] > i_threshold (unsigned, W bits, strict).
- o_eip = registered Eligible.
- Claim: on i_claim_req at edge t, if Eligible → o_claim_valid=1, o_claim_index=i_best_index, source → IN_SERVICE. Else o_claim_valid=0, o_claim_index=0, no state change.
- Simultaneous claim and complete in the same cycle: both processed. Claim uses the pre-edge Eligible. The complete applies to its own index, which cannot be the claimed one because that source is PENDING, not IN_SERVICE.
- Simultaneous i_irq rise and claim: new source not claimable in that cycle.
- Requests overlapping an outstanding ack are not supported; the requester waits for ack.

## Timing
- Reset (async assert, sync-released use): all states IDLE; o_pending=0, o_eip=0, o_claim_ack=0, o_claim_valid=0, o_claim_index=0, o_complete_ack=0.
- Reset mid-claim: ack is dropped; no pending ack after release.
- i_irq high at edge t → o_pending high after t → o_eip high after edge t+1 (2-cycle latency irq→eip).
- i_claim_req at edge t → o_claim_ack, o_claim_valid, o_claim_index valid for exactly one cycle after t. The claimed o_pending bit drops in the same cycle, and o_eip reflects the next winner after edge t+1.
- i_complete_req at edge t → o_complete_ack for one cycle after t. Source IDLE after t, PENDING after t+1 if irq still high.
- Threshold or enable change affects o_eip within 2 cycles.

## Test plan
- Reset with i_irq=4'b1111: all outputs 0 during reset; after release o_pending=4'b1111 (enable=all) one edge later, o_eip=1 one edge after that.
- Priorities {3,1,2,1}, threshold 0, irq[2:1] high: claim → valid=1, index=2. Second claim → index=1. Third claim → valid=0, index=0, o_eip=0.
- Threshold=2, only source 1 (priority 2) pending: o_eip=0; claim returns valid=0 and source 1 stays PENDING. Threshold=1 → o_eip=1 within 2 cycles.
- Claim source 3 with irq[3] held high: no re-pending while IN_SERVICE. Complete index 3 → ack next cycle, o_pending[3]=1 one cycle later. Complete index 0 (idle) → ack, no change.
- Same-cycle claim (winner 1) and complete of in-service 0: both acks next cycle; source 1 IN_SERVICE, source 0 IDLE.
- Assert i_rst asynchronously one cycle after i_claim_req: o_claim_ack and all state cleared immediately, no ack after release.
